// File: rtl/start_menu_select_pkg.sv
// Shared types and defaults for the start-screen menu selector.
// - start_menu_state_t : MENU (choosing), CONFIRM (blinking confirm), DONE (handed off)
// - geometry / colour defaults used as parameter defaults by start_menu_select
// - in_rect            : half-open rectangle membership test on 12-bit coordinates
package start_menu_select_pkg;

    typedef enum logic [1:0] {
        MENU,
        CONFIRM,
        DONE
    } start_menu_state_t;

    localparam int unsigned SCREEN_W         = 1024;
    localparam int unsigned SCREEN_H         = 768;

    localparam int unsigned OPT_X_DEF        = 412;
    localparam int unsigned OPT0_Y_DEF       = 300;
    localparam int unsigned OPT1_Y_DEF       = 400;
    localparam int unsigned BOX_W_DEF        = 200;
    localparam int unsigned BOX_H_DEF        = 60;
    localparam int unsigned BORDER_DEF       = 3;
    localparam int unsigned BLINK_FRAMES_DEF = 30;
    localparam int unsigned CONF_FRAMES_DEF  = 60;
    localparam logic [11:0] HL_COLOR_DEF     = 12'hFF0;

    // True when (x,y) lies in [x0, x0+w) x [y0, y0+h).
    function automatic logic in_rect(
        input logic [11:0] x,
        input logic [11:0] y,
        input logic [11:0] x0,
        input logic [11:0] y0,
        input logic [11:0] w,
        input logic [11:0] h
    );
        return (x >= x0) && (x < x0 + w) && (y >= y0) && (y < y0 + h);
    endfunction

endpackage

// File: rtl/start_menu_select_btn_edge.sv
// Rising-edge detector for the three menu buttons.
// - clk   : pixel clock
// - rst   : synchronous active-high reset (clears the previous-level register)
// - btn   : debounced button levels {enter, down, up}
// - pulse : one-cycle event per rising edge, same bit order as btn
module menu_btn_edge (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] btn,
    output logic [2:0] pulse
);

    logic [2:0] btn_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_q <= '0;
        end else begin
            btn_q <= btn;
        end
    end

    assign pulse = btn & ~btn_q;

endmodule

// File: rtl/start_menu_select.sv
// Start-screen menu selector: overlays a blinking highlight frame on the
// selected option box of the incoming VGA stream, tracks up/down selection,
// runs the confirm sequence and issues a one-cycle start_game pulse.
// - clk, rst          : pixel clock, synchronous active-high reset
// - menu_en           : start screen active; low forces pass-through and MENU
// - btn_up/down/enter : debounced button levels
// - in_*              : incoming VGA stream (timing + rgb)
// - out_*             : same stream registered one cycle, rgb possibly replaced
// - start_game        : one-cycle pulse when the confirm sequence completes
// - mode_sel          : committed selection, stable while start_game is high
module start_menu_select
    import start_menu_select_pkg::*;
#(
    parameter int unsigned OPT_X        = OPT_X_DEF,
    parameter int unsigned OPT0_Y       = OPT0_Y_DEF,
    parameter int unsigned OPT1_Y       = OPT1_Y_DEF,
    parameter int unsigned BOX_W        = BOX_W_DEF,
    parameter int unsigned BOX_H        = BOX_H_DEF,
    parameter int unsigned BORDER       = BORDER_DEF,
    parameter int unsigned BLINK_FRAMES = BLINK_FRAMES_DEF,
    parameter int unsigned CONF_FRAMES  = CONF_FRAMES_DEF,
    parameter logic [11:0] HL_COLOR     = HL_COLOR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        menu_en,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_enter,
    input  logic [10:0] in_hcount,
    input  logic [10:0] in_vcount,
    input  logic        in_hsync,
    input  logic        in_vsync,
    input  logic        in_hblnk,
    input  logic        in_vblnk,
    input  logic [11:0] in_rgb,
    output logic [10:0] out_hcount,
    output logic [10:0] out_vcount,
    output logic        out_hsync,
    output logic        out_vsync,
    output logic        out_hblnk,
    output logic        out_vblnk,
    output logic [11:0] out_rgb,
    output logic        start_game,
    output logic        mode_sel
);

    if ((OPT_X + BOX_W > SCREEN_W) || (OPT0_Y + BOX_H > SCREEN_H) ||
        (OPT1_Y + BOX_H > SCREEN_H)) begin : g_bad_geometry
        $error("start_menu_select: option box extends past the visible screen");
    end
    if ((2 * BORDER >= BOX_W) || (2 * BORDER >= BOX_H)) begin : g_bad_border
        $error("start_menu_select: BORDER too thick for the box size");
    end
    if ((BLINK_FRAMES < 1) || (CONF_FRAMES < 4)) begin : g_bad_frames
        $error("start_menu_select: BLINK_FRAMES must be >= 1 and CONF_FRAMES >= 4");
    end

    localparam int unsigned CNT_MAX = (BLINK_FRAMES > CONF_FRAMES) ? BLINK_FRAMES : CONF_FRAMES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [11:0] BOX_X0  = 12'(OPT_X);
    localparam logic [11:0] BOX_Y0  = 12'(OPT0_Y);
    localparam logic [11:0] BOX_Y1  = 12'(OPT1_Y);
    localparam logic [11:0] BOX_WW  = 12'(BOX_W);
    localparam logic [11:0] BOX_HH  = 12'(BOX_H);
    localparam logic [11:0] BRD     = 12'(BORDER);
    localparam logic [11:0] INNER_W = 12'(BOX_W - 2 * BORDER);
    localparam logic [11:0] INNER_H = 12'(BOX_H - 2 * BORDER);

    // ---------------------------------------------------------------
    // Button events and frame tick
    // ---------------------------------------------------------------
    logic [2:0] btn_ev;
    logic       up_ev;
    logic       down_ev;
    logic       enter_ev;

    menu_btn_edge u_btn_edge (
        .clk   (clk),
        .rst   (rst),
        .btn   ({btn_enter, btn_down, btn_up}),
        .pulse (btn_ev)
    );

    assign up_ev    = btn_ev[0];
    assign down_ev  = btn_ev[1];
    assign enter_ev = btn_ev[2];

    logic vblnk_q;
    logic frame_tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            vblnk_q <= 1'b0;
        end else begin
            vblnk_q <= in_vblnk;
        end
    end

    assign frame_tick = in_vblnk & ~vblnk_q;

    // ---------------------------------------------------------------
    // Menu FSM: state, shared frame counter, blink phase, start pulse
    // ---------------------------------------------------------------
    start_menu_state_t state;
    start_menu_state_t state_n;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_n;
    logic              blink_on;
    logic              blink_n;
    logic              start_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= MENU;
            cnt        <= '0;
            blink_on   <= 1'b1;
            start_game <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            blink_on   <= blink_n;
            start_game <= start_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        blink_n = blink_on;
        start_n = 1'b0;
        if (!menu_en) begin
            state_n = MENU;
            cnt_n   = '0;
            blink_n = 1'b1;
        end else begin
            unique case (state)
                MENU: begin
                    if (enter_ev) begin
                        state_n = CONFIRM;
                        cnt_n   = '0;
                        blink_n = 1'b1;
                    end else if (frame_tick) begin
                        if (cnt == CNT_W'(BLINK_FRAMES - 1)) begin
                            cnt_n   = '0;
                            blink_n = ~blink_on;
                        end else begin
                            cnt_n = cnt + CNT_W'(1);
                        end
                    end
                end
                CONFIRM: begin
                    if (frame_tick) begin
                        if (cnt == CNT_W'(CONF_FRAMES - 1)) begin
                            state_n = DONE;
                            cnt_n   = '0;
                            start_n = 1'b1;
                        end else begin
                            cnt_n = cnt + CNT_W'(1);
                            // Fast blink: flip on every 4th tick of the confirm count.
                            if (cnt[1:0] == 2'b11) begin
                                blink_n = ~blink_on;
                            end
                        end
                    end
                end
                DONE: begin
                end
                default: begin
                    state_n = MENU;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Selection: events update a pending choice that is committed only
    // at a frame tick so the highlight never moves mid-frame.
    // ---------------------------------------------------------------
    logic sel_pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_pending <= 1'b0;
            mode_sel    <= 1'b0;
        end else if (!menu_en || ((state == MENU) && enter_ev)) begin
            // Leaving the menu (or confirming) drops any uncommitted choice.
            sel_pending <= mode_sel;
        end else begin
            if ((state == MENU) && (up_ev ^ down_ev)) begin
                sel_pending <= down_ev;
            end
            if (frame_tick) begin
                mode_sel <= sel_pending;
            end
        end
    end

    // ---------------------------------------------------------------
    // Overlay and output register
    // ---------------------------------------------------------------
    logic [11:0] px_x;
    logic [11:0] px_y;
    logic [11:0] box_top;
    logic        in_outer;
    logic        in_inner;
    logic        highlight;

    always_comb begin
        px_x      = {1'b0, in_hcount};
        px_y      = {1'b0, in_vcount};
        box_top   = mode_sel ? BOX_Y1 : BOX_Y0;
        in_outer  = in_rect(px_x, px_y, BOX_X0, box_top, BOX_WW, BOX_HH);
        in_inner  = in_rect(px_x, px_y, BOX_X0 + BRD, box_top + BRD, INNER_W, INNER_H);
        highlight = in_outer && !in_inner && blink_on && (state != DONE) &&
                    menu_en && !in_hblnk && !in_vblnk;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_hcount <= '0;
            out_vcount <= '0;
            out_hsync  <= 1'b0;
            out_vsync  <= 1'b0;
            out_hblnk  <= 1'b0;
            out_vblnk  <= 1'b0;
            out_rgb    <= '0;
        end else begin
            out_hcount <= in_hcount;
            out_vcount <= in_vcount;
            out_hsync  <= in_hsync;
            out_vsync  <= in_vsync;
            out_hblnk  <= in_hblnk;
            out_vblnk  <= in_vblnk;
            out_rgb    <= highlight ? HL_COLOR : in_rgb;
        end
    end

endmodule

// File: tb/tb_start_menu_select.sv
// Self-checking bench for start_menu_select. Drives a sparse 1024x768 stream
// (probe pixels around both option boxes plus a short vertical blank per
// frame) and compares every output cycle against a behavioural model that
// works in frame counts rather than hardware counters.
module tb_start_menu_select;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        menu_en = 1'b1;
    logic        btn_up = 1'b0;
    logic        btn_down = 1'b0;
    logic        btn_enter = 1'b0;
    logic [10:0] in_hcount = '0;
    logic [10:0] in_vcount = '0;
    logic        in_hsync = 1'b0;
    logic        in_vsync = 1'b0;
    logic        in_hblnk = 1'b0;
    logic        in_vblnk = 1'b0;
    logic [11:0] in_rgb = '0;
    logic [10:0] out_hcount;
    logic [10:0] out_vcount;
    logic        out_hsync;
    logic        out_vsync;
    logic        out_hblnk;
    logic        out_vblnk;
    logic [11:0] out_rgb;
    logic        start_game;
    logic        mode_sel;

    start_menu_select dut (
        .clk        (clk),
        .rst        (rst),
        .menu_en    (menu_en),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_enter  (btn_enter),
        .in_hcount  (in_hcount),
        .in_vcount  (in_vcount),
        .in_hsync   (in_hsync),
        .in_vsync   (in_vsync),
        .in_hblnk   (in_hblnk),
        .in_vblnk   (in_vblnk),
        .in_rgb     (in_rgb),
        .out_hcount (out_hcount),
        .out_vcount (out_vcount),
        .out_hsync  (out_hsync),
        .out_vsync  (out_vsync),
        .out_hblnk  (out_hblnk),
        .out_vblnk  (out_vblnk),
        .out_rgb    (out_rgb),
        .start_game (start_game),
        .mode_sel   (mode_sel)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int pulses   = 0;

    // Probe pixels: corners, edges and interiors of both boxes.
    int px_x [16] = '{412, 420, 411, 611, 612, 414, 415, 608, 609, 412, 412, 412, 611, 415, 500, 500};
    int px_y [16] = '{300, 310, 300, 359, 300, 302, 303, 356, 356, 359, 360, 400, 459, 403, 401, 457};

    logic [2:0] hold     = 3'b000;
    bit         rand_rgb = 1'b0;
    bit         last_hl  = 1'b0;

    // Reference model (phase: 0 menu, 1 confirm, 2 done)
    bit m_prev_up, m_prev_dn, m_prev_en, m_prev_vb;
    int m_phase;
    int m_menu_ticks;
    int m_conf_ticks;
    bit m_pending, m_mode, m_start;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit frame_px(input int x, input int y, input bit sel);
        int top;
        bit outer;
        bit inner;
        top   = sel ? 400 : 300;
        outer = (x >= 412) && (x < 612) && (y >= top) && (y < top + 60);
        inner = (x >= 415) && (x < 609) && (y >= top + 3) && (y < top + 57);
        return outer && !inner;
    endfunction

    task automatic model_reset();
        m_prev_up = 0; m_prev_dn = 0; m_prev_en = 0; m_prev_vb = 0;
        m_phase = 0; m_menu_ticks = 0; m_conf_ticks = 0;
        m_pending = 0; m_mode = 0; m_start = 0;
    endtask

    // One clock: predict, advance the model, then compare after the edge.
    task automatic step();
        logic [25:0] exp_tim;
        logic [11:0] exp_rgb;
        bit blink, hl, up_ev, dn_ev, en_ev, tick, old_pending;
        exp_tim = {in_hcount, in_vcount, in_hsync, in_vsync, in_hblnk, in_vblnk};
        if (rst) begin
            exp_tim = '0;
            exp_rgb = '0;
            model_reset();
        end else begin
            if (m_phase == 0)      blink = ((m_menu_ticks / 30) % 2) == 0;
            else if (m_phase == 1) blink = ((m_conf_ticks / 4) % 2) == 0;
            else                   blink = 0;
            hl = menu_en && (m_phase != 2) && blink && !in_hblnk && !in_vblnk &&
                 frame_px(int'(in_hcount), int'(in_vcount), m_mode);
            exp_rgb = hl ? 12'hFF0 : in_rgb;

            up_ev = btn_up && !m_prev_up;
            dn_ev = btn_down && !m_prev_dn;
            en_ev = btn_enter && !m_prev_en;
            tick  = in_vblnk && !m_prev_vb;
            m_prev_up = btn_up; m_prev_dn = btn_down; m_prev_en = btn_enter; m_prev_vb = in_vblnk;

            m_start = 0;
            if (!menu_en) begin
                m_phase = 0; m_menu_ticks = 0; m_conf_ticks = 0; m_pending = m_mode;
            end else if (m_phase == 0) begin
                if (en_ev) begin
                    m_phase = 1; m_conf_ticks = 0; m_menu_ticks = 0; m_pending = m_mode;
                end else begin
                    old_pending = m_pending;
                    if (up_ev && !dn_ev) m_pending = 0;
                    else if (dn_ev && !up_ev) m_pending = 1;
                    if (tick) begin
                        m_menu_ticks++;
                        m_mode = old_pending;
                    end
                end
            end else if (m_phase == 1) begin
                if (tick) begin
                    m_conf_ticks++;
                    if (m_conf_ticks == 60) begin
                        m_phase = 2;
                        m_start = 1;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        check("out_timing", 32'({out_hcount, out_vcount, out_hsync, out_vsync, out_hblnk, out_vblnk}), 32'(exp_tim));
        check("out_rgb", 32'(out_rgb), 32'(exp_rgb));
        check("start_game", 32'(start_game), 32'(m_start));
        check("mode_sel", 32'(mode_sel), 32'(m_mode));
        if (start_game) pulses++;
    endtask

    // One frame: 16 probe pixels, 8 random pixels, 4 vertical-blank cycles.
    // 'press' is OR-ed onto the buttons for cycles [at, at+len).
    task automatic frame(input logic [2:0] press, input int at, input int len);
        logic [2:0] b;
        for (int i = 0; i < 28; i++) begin
            b = hold | (((i >= at) && (i < at + len)) ? press : 3'b000);
            {btn_enter, btn_down, btn_up} = b;
            in_hsync = 1'($urandom_range(0, 1));
            in_vsync = 1'($urandom_range(0, 1));
            in_rgb   = rand_rgb ? 12'($urandom) : 12'h123;
            if (i < 16) begin
                in_hcount = 11'(px_x[i]);
                in_vcount = 11'(px_y[i]);
                in_hblnk  = 1'b0;
                in_vblnk  = 1'b0;
            end else if (i < 24) begin
                in_hcount = 11'(400 + $urandom_range(0, 230));
                in_vcount = 11'($urandom_range(290, 470));
                in_hblnk  = ($urandom_range(0, 5) == 0);
                in_vblnk  = 1'b0;
            end else begin
                in_hcount = '0;
                in_vcount = 11'(768 + i - 24);
                in_hblnk  = 1'b1;
                in_vblnk  = 1'b1;
            end
            step();
            if (i == 0) last_hl = (out_rgb == 12'hFF0);
        end
        {btn_enter, btn_down, btn_up} = hold;
    endtask

    task automatic frames(input int n);
        for (int k = 0; k < n; k++) frame(3'b000, 0, 0);
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Blink: on for frames 0-29, off 30-59, on again at 60.
        for (int k = 0; k <= 60; k++) begin
            frame(3'b000, 0, 0);
            check("blink_frame", 32'(last_hl), 32'((k < 30) || (k == 60)));
        end

        // Down pulse mid-frame commits at the next frame tick.
        frame(3'b010, 5, 2);
        check("sel_commit_down", 32'(mode_sel), 32'd1);
        frames(1);
        // Back to option 0, then a long down hold gives exactly one change.
        frame(3'b001, 5, 2);
        frames(1);
        check("sel_commit_up", 32'(mode_sel), 32'd0);
        hold = 3'b010;
        frames(10);
        hold = 3'b000;
        frames(1);
        check("sel_hold_down", 32'(mode_sel), 32'd1);

        // Confirm with option 1: one pulse after 60 ticks, enter in DONE ignored.
        frame(3'b100, 5, 2);
        frames(64);
        check("confirm_pulses", 32'(pulses), 32'd1);
        check("confirm_mode", 32'(mode_sel), 32'd1);
        frame(3'b100, 5, 2);
        frames(2);
        check("done_enter_ignored", 32'(pulses), 32'd1);
        menu_en = 1'b0;
        frames(1);
        menu_en = 1'b1;

        // menu_en dropped during CONFIRM: no start pulse ever follows.
        frame(3'b100, 3, 1);
        frames(5);
        menu_en = 1'b0;
        frames(1);
        menu_en = 1'b1;
        frames(64);
        check("abort_menu_en", 32'(pulses), 32'd1);

        // Reset during CONFIRM.
        frame(3'b100, 3, 1);
        frames(5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_confirm_mode", 32'(mode_sel), 32'd0);
        frames(64);
        check("rst_confirm_pulses", 32'(pulses), 32'd1);

        // Simultaneous up+down does nothing.
        frame(3'b010, 5, 2);
        frames(1);
        frame(3'b011, 5, 2);
        frames(1);
        check("up_down_same", 32'(mode_sel), 32'd1);

        // Enter together with down: confirms with the old selection (0).
        frame(3'b001, 5, 2);
        frames(1);
        frame(3'b110, 7, 2);
        frames(62);
        check("enter_down_pulses", 32'(pulses), 32'd2);
        check("enter_down_mode", 32'(mode_sel), 32'd0);
        menu_en = 1'b0;
        frames(1);
        menu_en = 1'b1;

        // Randomised traffic.
        rand_rgb = 1'b1;
        for (int k = 0; k < 120; k++) begin
            menu_en = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 59) == 0) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
            end
            if ($urandom_range(0, 2) == 0)
                frame(3'($urandom_range(1, 7)), $urandom_range(0, 27), $urandom_range(1, 3));
            else
                frame(3'b000, 0, 0);
        end
        menu_en = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/start_menu_select.md
Name: start_menu_select

Overview:
- Downstream stage of the start-screen drawing chain. It consumes the composed start-screen VGA stream (background plus text) and overlays a blinking highlight frame around one of two menu options.
- It tracks operator selection from debounced buttons and runs a confirm sequence.
- It emits a one-cycle `start_game` pulse carrying the chosen mode to the game-control FSM.
- Output stream feeds the screen multiplexer and VGA output register.

Parameters:
- OPT_X, 412, left x of both option boxes (pixels)
- OPT0_Y, 300, top y of option 0 box
- OPT1_Y, 400, top y of option 1 box
- BOX_W, 200, box width (pixels)
- BOX_H, 60, box height (pixels)
- BORDER, 3, highlight frame thickness (pixels)
- BLINK_FRAMES, 30, frames per blink half-period in MENU
- CONF_FRAMES, 60, total frames spent in CONFIRM
- HL_COLOR, 12'hFF0, highlight RGB

Ports:
- clk, input, 1, pixel clock
- rst, input, 1, synchronous active-high reset
- menu_en, input, 1, start screen active; low forces pass-through and MENU state
- btn_up, input, 1, debounced level, synchronous to clk
- btn_down, input, 1, debounced level, synchronous to clk
- btn_enter, input, 1, debounced level, synchronous to clk
- in, vga_if.in, bundle, hcount[10:0], vcount[10:0], hsync, vsync, hblnk, vblnk, rgb[11:0]
- out, vga_if.out, bundle, same fields, delayed one cycle
- start_game, output, 1, one-cycle pulse on confirm completion
- mode_sel, output, 1, committed selection (0 or 1), stable while start_game is high

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - All `out` fields are 0.
  - start_game=0, mode_sel=0.
  - state=MENU, frame counter=0, blink_on=1.
  - Button edge registers are 0.
- Latency: every `out` field is `in` registered exactly 1 cycle. Timing fields are never altered; only rgb may be replaced.
- Frame tick: one-cycle internal strobe on the rising edge of in.vblnk (previous-value register).
- Button edges: a rising edge of each button produces a one-cycle event. A held button produces exactly one event.
- Selection:
  - up/down events in MENU set a pending selection (up sets 0, down sets 1). Events are ignored in other states.
  - Simultaneous up and down: no change.
  - Pending selection commits to mode_sel only on a frame tick. This keeps the highlight tear-free.
- FSM:
  - MENU: the blink counter counts frame ticks and toggles blink_on every BLINK_FRAMES ticks. An enter event moves to CONFIRM, clears the frame counter and sets blink_on=1. If enter coincides with an up/down event, enter wins and pending is discarded.
  - CONFIRM: blink_on toggles every 4 ticks. After CONF_FRAMES ticks, move to DONE.
  - DONE: assert start_game for exactly one cycle on entry, then stay in DONE with no overlay until menu_en falls.
  - menu_en=0 in any state: next state MENU, counters cleared, blink_on=1, mode_sel held. Output is pass-through in the same cycle.
- Overlay (combinational on `in`, then registered):
  - Active box top = mode_sel ? OPT1_Y : OPT0_Y.
  - A pixel is in the frame if it is inside [OPT_X, OPT_X+BOX_W) x [top, top+BOX_H) and not inside the region inset by BORDER on each side.
  - out.rgb = HL_COLOR when all of the following hold: frame pixel, blink_on, state≠DONE, menu_en, in.hblnk=0 and in.vblnk=0.
  - Otherwise out.rgb = in.rgb.
- Arithmetic: compare in 12 bits unsigned; no wrap. Boxes are assumed fully on-screen and are checked by parameter assertions.
- Reset mid-CONFIRM: state returns to MENU, mode_sel=0, and no start_game pulse is produced.

Decomposition:
- vga_pkg gains start_menu_state_t (MENU, CONFIRM, DONE) and the menu geometry and colour defaults.
- One sub-module, menu_btn_edge: a rising-edge detector for three buttons, 3-bit in to 3-bit pulse out, with synchronous reset.
- Frame-tick and overlay logic stay in the top.

Test Plan:
- Reset, then a 1024x768 timing stream with constant rgb=12'h123 and menu_en=1:
  - Pixel (412,300) outputs 12'hFF0 one cycle later.
  - Pixel (420,310) (interior) outputs 12'h123.
  - Timing fields equal inputs delayed 1 cycle.
- Blink: hold buttons idle for 61 frames → overlay present frames 0–29, absent 30–59, present frame 60.
- Selection commit: pulse btn_down mid-frame → mode_sel still 0 until next vblnk rise, then 1. Pixel (412,400) becomes HL_COLOR and (412,300) becomes rgb. A 10-frame btn_down hold gives one change only.
- Confirm: btn_enter with mode_sel=1 → after exactly 60 frame ticks, start_game is high for one cycle with mode_sel=1. After that the overlay is gone and a further btn_enter does nothing.
- Abort paths:
  - menu_en dropped in CONFIRM → pass-through immediately, no start_game.
  - rst in CONFIRM → mode_sel=0, state MENU.
  - Simultaneous up+down → no change.
  - Enter with down in the same cycle → CONFIRM with the old mode_sel.
